// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority event encoder: state encoding,
// wrap-around first-set search and population count.
package prio_enc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int         N_MAX    = 32;
  localparam logic [7:0] DROP_MAX = 8'd255;

  // First set bit of pending, searching upward from start and wrapping modulo n.
  // Only bits below n are considered; start is assumed to be below n.
  function automatic logic [4:0] ffs_from(input logic [N_MAX-1:0] pending,
                                          input logic [4:0]       start,
                                          input int               n);
    logic [4:0] idx;
    logic       found;
    int         j;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < n) begin
        j = int'(start) + i;
        if (j >= n) j = j - n;
        if (!found && pending[j[4:0]]) begin
          idx   = j[4:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

  function automatic logic [5:0] popcount(input logic [N_MAX-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_MAX; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_event_encoder_pick.sv
// Combinational selector: index of the first pending bit at or after start
// (wrapping), plus a flag telling whether any bit is pending at all.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = W'(ffs_from(N_MAX'(pending_i), 5'(start_i), N));
    any_o = |pending_i;
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Event encoder: request pulses accumulate in a pending register and are
// granted one index at a time over a valid/ready output.
// Define PRIO_RR_EN for round-robin selection; otherwise lowest index wins.
//
// state | meaning
// EMPTY | no grant held, out_valid low
// FULL  | out_idx/out_multi hold a grant, out_valid high
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_multi,
  output logic [N-1:0] pending_o,
  output logic [7:0]   drop_cnt
);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_q, idx_d;
  logic         multi_q, multi_d;
  logic [7:0]   drop_q, drop_d;

  logic [W-1:0] start;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         accept;
  logic         load;
  logic [N-1:0] load_clear;
  logic [N-1:0] merged;
  logic [8:0]   drop_sum;

`ifdef PRIO_RR_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .pending_i (pending_q),
    .start_i   (start),
    .idx_o     (sel_idx),
    .any_o     (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    multi_d    = multi_q;
    load_clear = '0;
`ifdef PRIO_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif

    accept = (state_q == FULL) && out_ready;
    load   = ((state_q == EMPTY) || accept) && sel_any;

    if ((state_q == EMPTY) || accept) begin
      state_d = sel_any ? FULL : EMPTY;
    end

    if (load) begin
      load_clear[sel_idx] = 1'b1;
      idx_d   = sel_idx;
      multi_d = popcount(N_MAX'(pending_q)) > 6'd1;
`ifdef PRIO_RR_EN
      rr_ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
`endif
    end

    // A req landing on the bit being granted this edge counts as a new event.
    pending_d = (pending_q & ~load_clear) | req_i;
    merged    = req_i & pending_q & ~load_clear;

    drop_sum = {1'b0, drop_q} + {3'b000, popcount(N_MAX'(merged))};
    drop_d   = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      idx_q     <= '0;
      multi_q   <= 1'b0;
      drop_q    <= '0;
`ifdef PRIO_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      drop_q    <= drop_d;
`ifdef PRIO_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_idx   = idx_q;
  assign out_multi = multi_q;
  assign pending_o = pending_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Scoreboard bench for prio_event_encoder: expected grants are queued with the
// stimulus and checked in order at every accepted handshake.
module tb_prio_event_encoder;

  localparam int N = 8;
  localparam int W = 3;

`ifdef PRIO_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_multi;
  logic [N-1:0] pending_o;
  logic [7:0]   drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] idx;
    logic         multi;
  } exp_t;

  exp_t exp_q[$];

  prio_event_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_multi (out_multi),
    .pending_o (pending_o),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic push(input int idx, input bit multi);
    exp_t e;
    e.idx   = W'(idx);
    e.multi = multi;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_i     = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    look();
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Handshake monitor: outputs are stable at the falling edge and the
  // transfer completes at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("grant_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("grant_idx", 32'(out_idx), 32'(e.idx));
        check_eq("grant_multi", 32'(out_multi), 32'(e.multi));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_i     = 8'hFF;
    out_ready = 1'b0;
    tick();
    tick();
    look();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_idx", 32'(out_idx), 32'd0);
    check_eq("rst_multi", 32'(out_multi), 32'd0);
    check_eq("rst_pending", 32'(pending_o), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);

    rst   = 1'b0;
    req_i = '0;
    repeat (3) tick();
    look();
    check_eq("idle_valid", 32'(out_valid), 32'd0);
    check_eq("idle_pending", 32'(pending_o), 32'd0);

    // single event: pending after one edge, grant after two
    out_ready = 1'b1;
    push(4, 1'b0);
    req_i = 8'h10;
    tick();
    req_i = '0;
    look();
    check_eq("single_pending", 32'(pending_o), 32'h10);
    check_eq("single_lat_valid0", 32'(out_valid), 32'd0);
    tick();
    look();
    check_eq("single_lat_valid1", 32'(out_valid), 32'd1);
    wait_drain(10);
    check_eq("single_pending_clr", 32'(pending_o), 32'd0);
    check_eq("single_empty", 32'(out_valid), 32'd0);

    // priority order with back-to-back grants
    do_reset();
    out_ready = 1'b1;
    push(2, 1'b1);
    push(5, 1'b1);
    push(7, 1'b0);
    req_i = 8'hA4;
    tick();
    req_i = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      look();
      check_eq("prio_nobubble", 32'(out_valid), 32'd1);
      tick();
    end
    wait_drain(5);
    check_eq("prio_empty", 32'(out_valid), 32'd0);

    // backpressure: pulse 1 granted, pulse 2 re-sets, pulse 3 merges
    do_reset();
    push(0, 1'b0);
    push(0, 1'b0);
    req_i = 8'h01;
    repeat (3) tick();
    req_i = '0;
    look();
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_idx", 32'(out_idx), 32'd0);
    check_eq("bp_drop", 32'(drop_cnt), 32'd1);
    check_eq("bp_pending", 32'(pending_o), 32'h01);
    repeat (2) tick();
    look();
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_idx", 32'(out_idx), 32'd0);
    out_ready = 1'b1;
    wait_drain(10);
    check_eq("bp_empty", 32'(out_valid), 32'd0);
    check_eq("bp_pending_clr", 32'(pending_o), 32'd0);
    check_eq("bp_drop_keep", 32'(drop_cnt), 32'd1);

    // saturation: first edge sets, second loads, every later edge merges
    do_reset();
    req_i = 8'h02;
    repeat (100) tick();
    look();
    check_eq("sat_drop_mid", 32'(drop_cnt), 32'd98);
    repeat (200) tick();
    look();
    check_eq("sat_drop_max", 32'(drop_cnt), 32'd255);
    check_eq("sat_hold_idx", 32'(out_idx), 32'd1);
    check_eq("sat_hold_valid", 32'(out_valid), 32'd1);

    // reset while a grant is held: it is discarded, not re-issued
    req_i = 8'hFF;
    rst   = 1'b1;
    tick();
    look();
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_drop", 32'(drop_cnt), 32'd0);
    check_eq("midrst_pending", 32'(pending_o), 32'd0);
    check_eq("midrst_idx", 32'(out_idx), 32'd0);
    rst       = 1'b0;
    req_i     = '0;
    out_ready = 1'b1;
    repeat (4) tick();
    look();
    check_eq("midrst_no_reissue", 32'(out_valid), 32'd0);

    // continuous 0x81: fixed priority starves 7 until requests stop
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(RR ? ((i % 2 == 1) ? 7 : 0) : 0, 1'b1);
    end
    push(RR ? 0 : 7, 1'b0);
    req_i = 8'h81;
    repeat (8) tick();
    req_i = '0;
    wait_drain(20);
    check_eq("rr_drop", 32'(drop_cnt), 32'd7);
    check_eq("rr_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
